// File: rtl/pc_fetch_queue_if.sv
// pc_fetch_queue_if
//   Bundles the instruction-ROM port, the execute-stage redirect and the
//   decode-side valid/ready handshake of the fetch front end.
//   master : the fetch unit (drives ROM address/enable and the decode head)
//   slave  : the surrounding pipeline (ROM, execute and decode)
interface pc_fetch_queue_if;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic        fetch_stall_o;

    modport master (
        output rom_ce_o, rom_addr_o, id_valid_o, id_inst_o, id_pc_o, fetch_stall_o,
        input  rom_inst_i, branch_flag_i, branch_target_i, id_ready_i
    );

    modport slave (
        input  rom_ce_o, rom_addr_o, id_valid_o, id_inst_o, id_pc_o, fetch_stall_o,
        output rom_inst_i, branch_flag_i, branch_target_i, id_ready_i
    );
endinterface

// File: rtl/pc_fetch_queue.sv
// pc_fetch_queue
//   Instruction-fetch front end. Owns the PC, drives the combinational ROM,
//   captures {pc, inst} pairs into a small FIFO and presents the head entry to
//   decode. Execute redirects override sequential fetch and flush the FIFO.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pc_fetch_queue_if.master (ROM port, redirect, decode handshake, stall)
module pc_fetch_queue #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_queue_if.master  bus
);
    localparam int unsigned      PTR_W    = $clog2(QUEUE_DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic             rom_ce_q, rom_ce_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      mem_pc_q   [QUEUE_DEPTH];
    logic [31:0]      mem_pc_d   [QUEUE_DEPTH];
    logic [31:0]      mem_inst_q [QUEUE_DEPTH];
    logic [31:0]      mem_inst_d [QUEUE_DEPTH];

    logic id_valid;
    logic pop;
    logic push;

    assign id_valid = (count_q != '0);
    assign pop      = id_valid && bus.id_ready_i;
    // A full queue may still accept a push when its head leaves this cycle.
    assign push     = rom_ce_q && !bus.branch_flag_i && ((count_q < FULL_CNT) || pop);

    assign bus.rom_ce_o      = rom_ce_q;
    assign bus.rom_addr_o    = pc_q;
    assign bus.id_valid_o    = id_valid;
    assign bus.id_pc_o       = id_valid ? mem_pc_q[rd_ptr_q]   : '0;
    assign bus.id_inst_o     = id_valid ? mem_inst_q[rd_ptr_q] : '0;
    assign bus.fetch_stall_o = (count_q == FULL_CNT) && !pop;

    always_comb begin
        pc_d       = pc_q;
        rom_ce_d   = 1'b1;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_pc_d   = mem_pc_q;
        mem_inst_d = mem_inst_q;

        if (bus.branch_flag_i) begin
            // Flush wins over any concurrent pop; the popped entry is simply dropped.
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = bus.branch_target_i & 32'hFFFF_FFFC;
        end else begin
            if (push) begin
                mem_pc_d[wr_ptr_q]   = pc_q;
                mem_inst_d[wr_ptr_q] = bus.rom_inst_i;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
                pc_d                 = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rom_ce_q <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                mem_pc_q[i]   <= '0;
                mem_inst_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            rom_ce_q   <= rom_ce_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_pc_q   <= mem_pc_d;
            mem_inst_q <= mem_inst_d;
        end
    end
endmodule

// File: tb/tb_pc_fetch_queue.sv
module tb_pc_fetch_queue;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_queue_if bus ();

    pc_fetch_queue #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0] + 16'h1234};
    endfunction

    assign bus.rom_inst_i = bus.rom_ce_o ? rom_word(bus.rom_addr_o) : 32'h0;

    // Reference model: a queue of fetched addresses plus the next fetch address.
    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_ce;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc = RST_PC;
        m_ce = 1'b0;
    endtask

    task automatic check_outputs(input string where);
        logic        v;
        logic        stall;
        v     = (m_q.size() != 0);
        stall = (m_q.size() == DEPTH) && !bus.id_ready_i;
        check({where, ".valid"}, 32'(bus.id_valid_o), 32'(v));
        check({where, ".pc"},    bus.id_pc_o,   v ? m_q[0] : 32'h0);
        check({where, ".inst"},  bus.id_inst_o, v ? rom_word(m_q[0]) : 32'h0);
        check({where, ".stall"}, 32'(bus.fetch_stall_o), 32'(stall));
        check({where, ".addr"},  bus.rom_addr_o, m_pc);
        check({where, ".ce"},    32'(bus.rom_ce_o), 32'(m_ce));
    endtask

    // One cycle: inputs applied at negedge, outputs checked, then the edge.
    task automatic step(input string where, input logic rdy, input logic br, input logic [31:0] tgt);
        logic pop;
        logic push;
        bus.id_ready_i      = rdy;
        bus.branch_flag_i   = br;
        bus.branch_target_i = tgt;
        #1;
        check_outputs(where);
        pop  = (m_q.size() != 0) && rdy;
        push = m_ce && !br && ((m_q.size() < DEPTH) || pop);
        @(posedge clk);
        if (br) begin
            m_q.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        m_ce = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.id_ready_i      = 1'b0;
        bus.branch_flag_i   = 1'b0;
        bus.branch_target_i = 32'h0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset");

        // 1: streaming with ready held high
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step("stream", 1'b1, 1'b0, 32'h0);

        // 2: backpressure after reset
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b0, 32'h0);
        #1;
        check("hold.stall_const", 32'(bus.fetch_stall_o), 32'd1);
        check("hold.addr_const", bus.rom_addr_o, 32'h8);
        for (int i = 0; i < 4; i++) step("drain", 1'b1, 1'b0, 32'h0);

        // 3: redirect with two entries queued
        for (int i = 0; i < 3; i++) step("fill3", 1'b0, 1'b0, 32'h0);
        step("br40", 1'b0, 1'b1, 32'h40);
        #1;
        check("br40.valid_const", 32'(bus.id_valid_o), 32'd0);
        check("br40.addr_const", bus.rom_addr_o, 32'h40);
        step("br40.a", 1'b1, 1'b0, 32'h0);
        #1;
        check("br40.pc_const", bus.id_pc_o, 32'h40);
        step("br40.b", 1'b1, 1'b0, 32'h0);

        // 4: unaligned target
        step("br43", 1'b1, 1'b1, 32'h43);
        #1;
        check("br43.addr_const", bus.rom_addr_o, 32'h40);
        for (int i = 0; i < 3; i++) step("br43.run", 1'b1, 1'b0, 32'h0);

        // 5: redirect together with a pop of a full queue
        for (int i = 0; i < 3; i++) step("fill5", 1'b0, 1'b0, 32'h0);
        step("brpop", 1'b1, 1'b1, 32'h100);
        #1;
        check("brpop.valid_const", 32'(bus.id_valid_o), 32'd0);
        for (int i = 0; i < 5; i++) step("brpop.run", 1'b1, 1'b0, 32'h0);

        // 6: asynchronous reset with a full queue
        for (int i = 0; i < 3; i++) step("fill6", 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid", 32'(bus.id_valid_o), 32'd0);
        check("arst.ce", 32'(bus.rom_ce_o), 32'd0);
        check("arst.addr", bus.rom_addr_o, RST_PC);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step("restart", 1'b1, 1'b0, 32'h0);

        // Random traffic including wrap near the top of the address space
        step("brtop", 1'b1, 1'b1, 32'hFFFF_FFF5);
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        b;
            logic [31:0] t;
            r = ($urandom_range(0, 9) < 7);
            b = ($urandom_range(0, 99) < 8);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                            : $urandom;
            step("rand", r, b, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
